rv_plic_claim_agent: RTL and testbench
======================================

// Module: rv_plic_claim_agent
// PURPOSE
//  Hart-side initiator for the PLIC claim/complete protocol. Watches one target's irq line and
//  issues a TL-UL Get to that target's CC register to claim the highest-priority pending source.
//  Hands the claimed ID to a local consumer with a valid/ready handshake, waits for service-done,
//  then issues a TL-UL PutFullData of the same ID to CC to complete it. Sits between the PLIC
//  target output and a core or DMA engine that has no software interrupt handler.
// PARAMETERS
//  CcAddr   32'h0000_0204  byte address of the target's claim/complete (CC) register
//  SrcW     6              width of the interrupt ID (clog2 of the PLIC source count)
//  SourceId 8'h00          a_source value driven on all TL-UL requests
//  CntW     8              width of the spurious-claim counter
// PORTS
//  clk_i        in   1          clock
//  rst_ni       in   1          asynchronous active-low reset
//  tl_o         out  tlul_h2d_t TL-UL host request channel A and d_ready
//  tl_i         in   tlul_d2h_t TL-UL host response channel D and a_ready
//  en_i         in   1          agent enable; sampled only in IDLE
//  irq_i        in   1          PLIC target interrupt notification
//  id_o         out  SrcW       claimed interrupt ID
//  id_valid_o   out  1          id_o valid
//  id_ready_i   in   1          consumer accepts id_o
//  done_i       in   1          consumer finished servicing the accepted ID (1-cycle pulse)
//  busy_o       out  1          FSM not in IDLE
//  err_o        out  1          sticky; set on any d_error; cleared only by reset
//  spurious_o   out  CntW       count of claims returning ID 0; saturates at all-ones
// BEHAVIOUR
//  Reset: FSM=IDLE. All tl_o fields 0 except d_ready=1. id_o=0, id_valid_o=0, busy_o=0, err_o=0, spurious_o=0.
//  All outputs are registered. tl_o.d_ready is held at 1.
//  FSM:
//   IDLE     : en_i && irq_i -> CLM_REQ. The next cycle drives a_valid=1.
//   CLM_REQ  : a_valid=1, a_opcode=Get(4), a_address=CcAddr, a_size=2, a_mask=4'hF, a_data=0.
//              Stay until a_ready; on a_valid&&a_ready go to CLM_RSP and drop a_valid the next cycle.
//   CLM_RSP  : wait for d_valid. Let id = d_data[SrcW-1:0].
//              d_error          -> set err_o, go to IDLE.
//              id==0            -> spurious_o += 1 (saturating), go to IDLE.
//              otherwise        -> latch id into id_o, set id_valid_o=1, go to DELIVER.
//   DELIVER  : hold id_valid_o and id_o stable until id_ready_i. On handshake go to SERVICE;
//              id_valid_o is 0 the next cycle.
//   SERVICE  : wait for done_i. done_i seen in any other state is ignored.
//              If done_i arrives in the same cycle as the DELIVER handshake, it is not captured.
//   CMP_REQ  : a_valid=1, a_opcode=PutFullData(0), a_address=CcAddr, a_data={'0,id_o},
//              a_mask=4'hF, a_size=2. Hold until a_ready.
//   CMP_RSP  : wait for d_valid. If d_error, set err_o. Go to IDLE in either case.
//  Channel A fields are stable while a_valid && !a_ready, per TL-UL.
//  Exactly one outstanding transaction. A d_valid in a non-RSP state is accepted and dropped.
//  irq_i and en_i are ignored outside IDLE. irq_i dropping mid-sequence does not abort the sequence.
//  Deasserting en_i mid-sequence lets the current sequence finish.
//  Minimum latency: irq_i sampled high in IDLE at edge N gives a_valid=1 after edge N+1.
//   With a_ready=1 and zero-wait d_valid, id_valid_o rises 3 cycles after irq_i is sampled.
//  Back-to-back: after CMP_RSP->IDLE, an irq_i still high starts a new claim with no extra bubble
//   beyond the IDLE cycle.
//  Reset mid-operation: the FSM returns to IDLE immediately, and any in-flight TL-UL transaction is
//   abandoned. The PLIC and the bus must share this reset.
// TESTING
//  T1 basic: CcAddr model returns ID 5. Pulse irq_i, id_ready_i=1, then done_i 4 cycles later ->
//     one Get to 0x204, id_o=5 with id_valid_o, one PutFullData with a_data=5, err_o=0.
//  T2 spurious: claim response d_data=0 -> no id_valid_o, spurious_o=1, FSM back in IDLE.
//     Repeat 300 times with CntW=8 -> spurious_o=255.
//  T3 backpressure: a_ready held low 7 cycles and id_ready_i low 10 cycles -> a_valid, a_address and
//     id_o stay stable, with exactly one Get and one Put issued.
//  T4 error: d_error=1 on claim -> err_o=1 and no Put issued. A later good claim of ID 3 completes
//     normally and err_o stays 1.
//  T5 back-to-back: irq_i held high; the model returns 7 then 9 -> two full claim/complete sequences
//     in order 7 then 9, with no overlap of transactions.
//  T6 reset: assert rst_ni low during SERVICE with id 12 -> all outputs at reset values
//     asynchronously and no Put issued after reset releases.

Source files
------------

// File: rtl/rv_plic_claim_agent.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv_plic_claim_agent                                                        |
// | Hart-side PLIC claim/complete initiator over TL-UL with local ID handoff.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package rv_plic_claim_agent_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tlul_d2h_t;
endpackage

module rv_plic_claim_agent
  import rv_plic_claim_agent_pkg::*;
#(
  parameter logic [31:0] CcAddr   = 32'h0000_0204,
  parameter int          SrcW     = 6,
  parameter logic [7:0]  SourceId = 8'h00,
  parameter int          CntW     = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output tlul_h2d_t       tl_o,
  input  tlul_d2h_t       tl_i,
  input  logic            en_i,
  input  logic            irq_i,
  output logic [SrcW-1:0] id_o,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  input  logic            done_i,
  output logic            busy_o,
  output logic            err_o,
  output logic [CntW-1:0] spurious_o
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_clm_req = 3'd1;
  localparam logic [2:0] c_st_clm_rsp = 3'd2;
  localparam logic [2:0] c_st_deliver = 3'd3;
  localparam logic [2:0] c_st_service = 3'd4;
  localparam logic [2:0] c_st_cmp_req = 3'd5;
  localparam logic [2:0] c_st_cmp_rsp = 3'd6;

  localparam logic [2:0] c_op_get = 3'd4;
  localparam logic [2:0] c_op_put = 3'd0;

  logic [2:0]      r_state, w_state;
  tlul_h2d_t       r_tl, w_tl;
  logic [SrcW-1:0] r_id, w_id;
  logic            r_id_valid, w_id_valid;
  logic            r_busy, w_busy;
  logic            r_err, w_err;
  logic [CntW-1:0] r_spur, w_spur;

  logic            w_a_hs;
  logic [SrcW-1:0] w_rsp_id;
  logic            w_unused_d;

  assign w_a_hs   = r_tl.a_valid & tl_i.a_ready;
  assign w_rsp_id = tl_i.d_data[SrcW-1:0];
  assign w_unused_d = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                        tl_i.d_sink, tl_i.d_data[31:SrcW]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= c_st_idle;
      r_tl       <= '0;
      r_tl.d_ready <= 1'b1;
      r_id       <= '0;
      r_id_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_spur     <= '0;
    end else begin
      r_state    <= w_state;
      r_tl       <= w_tl;
      r_id       <= w_id;
      r_id_valid <= w_id_valid;
      r_busy     <= w_busy;
      r_err      <= w_err;
      r_spur     <= w_spur;
    end
  end

  always_comb begin
    w_state = r_state;
    case (r_state)
      c_st_idle:    if (en_i && irq_i) w_state = c_st_clm_req;
      c_st_clm_req: if (w_a_hs) w_state = c_st_clm_rsp;
      c_st_clm_rsp: begin
        if (tl_i.d_valid) begin
          if (tl_i.d_error || (w_rsp_id == '0)) w_state = c_st_idle;
          else                                   w_state = c_st_deliver;
        end
      end
      c_st_deliver: if (id_ready_i) w_state = c_st_service;
      c_st_service: if (done_i) w_state = c_st_cmp_req;
      c_st_cmp_req: if (w_a_hs) w_state = c_st_cmp_rsp;
      c_st_cmp_rsp: if (tl_i.d_valid) w_state = c_st_idle;
      default:      w_state = c_st_idle;
    endcase
  end

  // Request fields are loaded only when a_valid rises, so they hold through a stall.
  always_comb begin
    w_tl         = r_tl;
    w_tl.d_ready = 1'b1;
    w_id         = r_id;
    w_id_valid   = r_id_valid;
    w_err        = r_err;
    w_spur       = r_spur;
    w_busy       = (w_state != c_st_idle);

    if (w_a_hs) begin
      w_tl.a_valid = 1'b0;
    end else if (((r_state == c_st_clm_req) || (r_state == c_st_cmp_req)) && !r_tl.a_valid) begin
      w_tl.a_valid   = 1'b1;
      w_tl.a_opcode  = (r_state == c_st_clm_req) ? c_op_get : c_op_put;
      w_tl.a_param   = 3'd0;
      w_tl.a_size    = 2'd2;
      w_tl.a_source  = SourceId;
      w_tl.a_address = CcAddr;
      w_tl.a_mask    = 4'hF;
      w_tl.a_data    = (r_state == c_st_clm_req) ? 32'd0 : {{(32-SrcW){1'b0}}, r_id};
    end

    if ((r_state == c_st_clm_rsp) && tl_i.d_valid) begin
      if (tl_i.d_error) begin
        w_err = 1'b1;
      end else if (w_rsp_id == '0) begin
        if (r_spur != '1) w_spur = r_spur + 1'b1;
      end else begin
        w_id       = w_rsp_id;
        w_id_valid = 1'b1;
      end
    end

    if ((r_state == c_st_deliver) && id_ready_i) w_id_valid = 1'b0;

    if ((r_state == c_st_cmp_rsp) && tl_i.d_valid && tl_i.d_error) w_err = 1'b1;
  end

  assign tl_o       = r_tl;
  assign id_o       = r_id;
  assign id_valid_o = r_id_valid;
  assign busy_o     = r_busy;
  assign err_o      = r_err;
  assign spurious_o = r_spur;

endmodule
`default_nettype wire

// File: tb/tb_rv_plic_claim_agent.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rv_plic_claim_agent                                                     |
// | Scoreboard bench: TL-UL target model, ID consumer, queued expectations.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rv_plic_claim_agent;
  import rv_plic_claim_agent_pkg::*;

  localparam logic [31:0] CC = 32'h0000_0204;

  typedef struct { logic [2:0] op; logic [31:0] data; } req_t;
  typedef struct { logic [31:0] data; logic err; } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, irq = 1'b0, id_ready = 1'b0;
  logic done_m = 1'b0, done_s = 1'b0, done_en = 1'b1;
  logic a_rdy = 1'b1, d_valid = 1'b0, d_error = 1'b0;
  logic [31:0] d_data = '0;
  tlul_h2d_t tl_o;
  tlul_d2h_t tl_i;
  logic [5:0] id_o;
  logic id_valid, busy, err;
  logic [7:0] spur;

  always_comb begin
    tl_i         = '0;
    tl_i.a_ready = a_rdy;
    tl_i.d_valid = d_valid;
    tl_i.d_data  = d_data;
    tl_i.d_error = d_error;
    tl_i.d_size  = 2'd2;
  end

  rv_plic_claim_agent #(.CcAddr(CC), .SrcW(6), .SourceId(8'h00), .CntW(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tl_o(tl_o), .tl_i(tl_i), .en_i(en), .irq_i(irq),
    .id_o(id_o), .id_valid_o(id_valid), .id_ready_i(id_ready), .done_i(done_m | done_s),
    .busy_o(busy), .err_o(err), .spurious_o(spur)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_get = 0, n_put = 0, n_id = 0;
  req_t exp_req[$];
  logic [5:0] exp_id[$];
  rsp_t rsp_q[$];
  logic hs_a_prev = 1'b0, hs_id_prev = 1'b0, outstanding = 1'b0;
  logic a_stall = 1'b0, id_stall = 1'b0;
  tlul_h2d_t a_saved;
  logic [5:0] id_saved;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, pops expectations on every handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_a_prev = 1'b0; hs_id_prev = 1'b0; a_stall = 1'b0; id_stall = 1'b0; outstanding = 1'b0;
    end else begin
      if (a_stall) begin
        chk("a_stable_valid", tl_o.a_valid, 1);
        chk("a_stable_addr", tl_o.a_address, a_saved.a_address);
        chk("a_stable_op_data", {tl_o.a_opcode, tl_o.a_data}, {a_saved.a_opcode, a_saved.a_data});
      end
      if (id_stall) chk("id_stable", {id_valid, id_o}, {1'b1, id_saved});
      if (d_valid) outstanding = 1'b0;
      if (tl_o.a_valid && a_rdy) begin
        chk("one_outstanding", outstanding, 0);
        if (exp_req.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_a_beat: got opcode %0d data %0h expected none", tl_o.a_opcode, tl_o.a_data);
        end else begin
          req_t e;
          e = exp_req.pop_front();
          chk("a_opcode", tl_o.a_opcode, e.op);
          chk("a_address", tl_o.a_address, CC);
          chk("a_data", tl_o.a_data, e.data);
          chk("a_mask_size", {tl_o.a_mask, tl_o.a_size, tl_o.a_source}, {4'hF, 2'd2, 8'h00});
        end
        if (tl_o.a_opcode == 3'd4) n_get++; else n_put++;
        outstanding = 1'b1;
      end
      if (id_valid && id_ready) begin
        if (exp_id.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_id: got %0d expected none", id_o);
        end else begin
          chk("id_value", id_o, exp_id.pop_front());
        end
        n_id++;
      end
      a_stall    = tl_o.a_valid && !a_rdy;
      a_saved    = tl_o;
      id_stall   = id_valid && !id_ready;
      id_saved   = id_o;
      hs_a_prev  = tl_o.a_valid && a_rdy;
      hs_id_prev = id_valid && id_ready;
    end
  end

  // TL-UL target with zero-wait response, plus a consumer that finishes 4 cycles after accepting.
  initial begin
    int timer;
    rsp_t r;
    timer = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        d_valid = 1'b0; d_data = '0; d_error = 1'b0; done_m = 1'b0; timer = 0;
      end else begin
        if (hs_a_prev) begin
          r = '{data: 32'd0, err: 1'b0};
          if (rsp_q.size() > 0) r = rsp_q.pop_front();
          d_valid = 1'b1; d_data = r.data; d_error = r.err;
        end else begin
          d_valid = 1'b0; d_data = '0; d_error = 1'b0;
        end
        if (hs_id_prev && done_en) begin
          timer = 4; done_m = 1'b0;
        end else if (timer > 0) begin
          timer--; done_m = (timer == 0);
        end else begin
          done_m = 1'b0;
        end
      end
    end
  end

  task automatic expect_claim(input logic [5:0] id, input logic e);
    exp_req.push_back('{op: 3'd4, data: 32'd0});
    rsp_q.push_back('{data: {26'h3FF_FFFF & 26'h0, id} | (e ? 32'hFFFF_FF00 : 32'h0), err: e});
    if (!e && id != 0) begin
      exp_id.push_back(id);
      exp_req.push_back('{op: 3'd0, data: {26'd0, id}});
      rsp_q.push_back('{data: 32'd0, err: 1'b0});
    end
  endtask

  task automatic pulse_irq();
    @(posedge clk); #1 irq = 1'b1;
    @(posedge clk); #1 irq = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    repeat (2) begin @(posedge clk); #1; end
    for (i = 0; i < 400 && busy; i++) begin @(posedge clk); #1; end
    chk(name, busy, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a_ctrl"}, {tl_o.a_valid, tl_o.a_opcode, tl_o.a_param, tl_o.a_size,
                           tl_o.a_source, tl_o.a_mask, tl_o.d_ready}, 1);
    chk({tag, "_a_addr_data"}, {tl_o.a_address, tl_o.a_data}, 0);
    chk({tag, "_outs"}, {id_o, id_valid, busy, err, spur}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g, p, k;
    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    rst_n = 1'b1; en = 1'b1; id_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_reset("post_reset");

    // T1 basic, with minimum-latency checks
    g = n_get; p = n_put;
    expect_claim(6'd5, 1'b0);
    pulse_irq();
    chk("t1_a_valid_n", tl_o.a_valid, 0);
    @(posedge clk); #1 chk("t1_a_valid_n1", tl_o.a_valid, 1);
    @(posedge clk); #1 chk("t1_id_valid_n2", id_valid, 0);
    @(posedge clk); #1 chk("t1_id_valid_n3", {id_valid, id_o}, {1'b1, 6'd5});
    wait_idle("t1_idle");
    chk("t1_counts", {n_get - g, n_put - p}, {32'd1, 32'd1});
    chk("t1_err", err, 0);

    // T2 spurious claims and saturation
    expect_claim(6'd0, 1'b0);
    pulse_irq();
    wait_idle("t2_idle");
    chk("t2_spur_one", spur, 1);
    for (k = 0; k < 299; k++) begin
      expect_claim(6'd0, 1'b0);
      pulse_irq();
      wait_idle("t2_idle_loop");
    end
    chk("t2_spur_sat", spur, 8'd255);

    // T3 backpressure on both A channel and consumer
    g = n_get; p = n_put;
    expect_claim(6'd11, 1'b0);
    a_rdy = 1'b0; id_ready = 1'b0;
    pulse_irq();
    for (k = 0; k < 20 && !tl_o.a_valid; k++) begin @(posedge clk); #1; end
    chk("t3_a_valid_seen", tl_o.a_valid, 1);
    repeat (7) @(posedge clk);
    #1 a_rdy = 1'b1;
    for (k = 0; k < 20 && !id_valid; k++) begin @(posedge clk); #1; end
    chk("t3_id_valid_seen", {id_valid, id_o}, {1'b1, 6'd11});
    repeat (10) @(posedge clk);
    #1 id_ready = 1'b1;
    wait_idle("t3_idle");
    chk("t3_counts", {n_get - g, n_put - p}, {32'd1, 32'd1});

    // T4 error response on claim, then a good claim
    g = n_get; p = n_put;
    expect_claim(6'd9, 1'b1);
    pulse_irq();
    wait_idle("t4_idle");
    chk("t4_err_set", err, 1);
    chk("t4_no_put", {n_get - g, n_put - p}, {32'd1, 32'd0});
    expect_claim(6'd3, 1'b0);
    pulse_irq();
    wait_idle("t4_idle2");
    chk("t4_good_claim", {n_get - g, n_put - p}, {32'd2, 32'd1});
    chk("t4_err_sticky", err, 1);

    // T5 back-to-back with irq held high
    g = n_get; p = n_put;
    expect_claim(6'd7, 1'b0);
    expect_claim(6'd9, 1'b0);
    @(posedge clk); #1 irq = 1'b1;
    for (k = 0; k < 200 && (n_put - p) < 2; k++) begin @(posedge clk); #1; end
    irq = 1'b0;
    wait_idle("t5_idle");
    chk("t5_counts", {n_get - g, n_put - p}, {32'd2, 32'd2});

    // T6 asynchronous reset while in SERVICE
    g = n_get; p = n_put;
    done_en = 1'b0;
    exp_req.push_back('{op: 3'd4, data: 32'd0});
    exp_id.push_back(6'd12);
    rsp_q.push_back('{data: 32'd12, err: 1'b0});
    k = n_id;
    pulse_irq();
    for (int i = 0; i < 30 && n_id == k; i++) begin @(posedge clk); #1; end
    chk("t6_delivered", n_id - k, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("t6_async");
    @(posedge clk); #1 rst_n = 1'b1;
    done_en = 1'b1;
    @(posedge clk); #1 done_s = 1'b1;
    @(posedge clk); #1 done_s = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("t6_no_put", {n_get - g, n_put - p}, {32'd1, 32'd0});
    chk("t6_idle", {busy, tl_o.a_valid, err}, 0);

    chk("drained", {exp_req.size(), exp_id.size()}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
